// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A granted requester may keep the port for up to BURST_LEN consecutive beats.
// The arbiter also drives the FIFO's clr pin for flushes.
//
// Handshake: requester i offers a beat by raising req[i] with its data on
// req_data. The beat is consumed on the rising edge where gnt[i] is high.
// Towards the FIFO, enq acts as valid and full_n as ready. enq is never
// raised while full_n is low, so every enq pulse is a completed write.
module fifo_enq_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 4,
  parameter int BURST_LEN  = 2,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          flush,
  input  logic                          full_n,
  output logic                          enq,
  output logic [DATA_WIDTH-1:0]         din,
  output logic                          clr,
  output logic [IDX_WIDTH-1:0]          owner,
  output logic                          busy
);

  localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // All registered arbiter state in one struct so it can be probed as a unit.
  typedef struct packed {
    state_t               state;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] owner;
    logic [CNT_WIDTH-1:0] beat_cnt;
  } regs_t;

  regs_t r;
  regs_t r_n;

  logic                 hold_owner;
  logic                 found;
  logic                 beat;
  logic [IDX_WIDTH-1:0] search_start;
  logic [IDX_WIDTH-1:0] winner;
  logic [IDX_WIDTH-1:0] idx;
  logic [IDX_WIDTH:0]   sum;

  // Next index in ring order; NUM_REQ need not be a power of two.
  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] i);
    if (i >= IDX_WIDTH'(NUM_REQ - 1)) return '0;
    return i + IDX_WIDTH'(1);
  endfunction

  // Winner selection: the holding owner wins outright; otherwise scan the ring.
  always_comb begin
    hold_owner   = (r.state == HOLD) && req[r.owner];
    search_start = (r.state == HOLD) ? wrap_inc(r.owner) : r.rr_ptr;
    found        = 1'b0;
    winner       = '0;
    idx          = '0;
    sum          = '0;
    if (hold_owner) begin
      found  = 1'b1;
      winner = r.owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, search_start} + (IDX_WIDTH + 1)'(k);
        if (sum >= (IDX_WIDTH + 1)'(NUM_REQ)) sum = sum - (IDX_WIDTH + 1)'(NUM_REQ);
        idx = sum[IDX_WIDTH-1:0];
        if (!found && req[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
  end

  // Port outputs: a beat needs a winner, FIFO space, no flush and no reset.
  always_comb begin
    beat  = full_n && found && !flush && !rst;
    enq   = beat;
    gnt   = '0;
    din   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (beat && (winner == IDX_WIDTH'(i))) begin
        gnt[i] = 1'b1;
        din    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    clr   = flush;
    owner = r.owner;
    busy  = (r.state == HOLD);
  end

  // Next-state logic for the ownership FSM.
  always_comb begin
    r_n = r;
    if (flush) begin
      r_n.state    = IDLE;
      r_n.rr_ptr   = '0;
      r_n.beat_cnt = '0;
    end else if (hold_owner) begin
      // Owner still requesting: stall on backpressure, else count the beat.
      if (beat) begin
        r_n.beat_cnt = r.beat_cnt + CNT_WIDTH'(1);
        if (r.beat_cnt + CNT_WIDTH'(1) == CNT_WIDTH'(BURST_LEN)) begin
          r_n.rr_ptr = wrap_inc(r.owner);
          r_n.state  = IDLE;
        end
      end
    end else if (beat) begin
      // New ownership, either from IDLE or from a same-cycle release.
      r_n.owner    = winner;
      r_n.beat_cnt = CNT_WIDTH'(1);
      if (BURST_LEN == 1) begin
        r_n.rr_ptr = wrap_inc(winner);
        r_n.state  = IDLE;
      end else begin
        r_n.state  = HOLD;
      end
    end else if (r.state == HOLD) begin
      // Owner released with nothing to hand over: resume after the old owner.
      r_n.rr_ptr = wrap_inc(r.owner);
      r_n.state  = IDLE;
    end
  end

  // State register; reset abandons any burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r <= '{state: IDLE, rr_ptr: '0, owner: '0, beat_cnt: '0};
    else     r <= r_n;
  end

endmodule
